// File: rtl/uart_cmd_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_initiator_if
// Description : Bundles the local request/response handshake and the
//               byte-level UART TX/RX signals of the command initiator.
//                 master : initiator view (drives frames and responses)
//                 slave  : environment view (request logic, TX FIFO, RX)
//               Signals:
//                 req_valid_p/req_ready_p/req_write_p/req_adrs_p/req_wr_data_p
//                   local request handshake
//                 tx_byte_p/tx_byte_valid_p/tx_byte_ready_p
//                   byte stream towards the TX FIFO write side
//                 rx_byte_p/rx_byte_valid_p
//                   received-byte strobe from the RX stage
//                 rsp_data_p/rsp_valid_p/rsp_timeout_p/busy_p
//                   read response and status back to request logic
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_initiator_if;
  logic        req_valid_p;
  logic        req_write_p;
  logic [15:0] req_adrs_p;
  logic [15:0] req_wr_data_p;
  logic        req_ready_p;
  logic [7:0]  tx_byte_p;
  logic        tx_byte_valid_p;
  logic        tx_byte_ready_p;
  logic [7:0]  rx_byte_p;
  logic        rx_byte_valid_p;
  logic [15:0] rsp_data_p;
  logic        rsp_valid_p;
  logic        rsp_timeout_p;
  logic        busy_p;

  modport master (
    input  req_valid_p, req_write_p, req_adrs_p, req_wr_data_p,
    input  tx_byte_ready_p, rx_byte_p, rx_byte_valid_p,
    output req_ready_p, tx_byte_p, tx_byte_valid_p,
    output rsp_data_p, rsp_valid_p, rsp_timeout_p, busy_p
  );

  modport slave (
    output req_valid_p, req_write_p, req_adrs_p, req_wr_data_p,
    output tx_byte_ready_p, rx_byte_p, rx_byte_valid_p,
    input  req_ready_p, tx_byte_p, tx_byte_valid_p,
    input  rsp_data_p, rsp_valid_p, rsp_timeout_p, busy_p
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_initiator
// Description : Requester end of the UART memory-map protocol. Builds the
//               frame 0x01, cmd (0x02 read / 0x03 write), adrs MSB, adrs LSB
//               [, wdata MSB, wdata LSB] and, for reads, collects the two
//               response bytes into a 16-bit word with a response timeout.
// Ports       : clk210_p  - system clock, rising edge
//               reset_n_p - asynchronous active-low reset
//               bus       - uart_cmd_initiator_if.master (request, TX bytes,
//                           RX strobe, response and status)
// Parameters  : TIMEOUT_CYCLES - cycles from acceptance of the last frame
//               byte until the second response byte must have arrived
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_initiator #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_100_000
) (
  input  logic                        clk210_p,
  input  logic                        reset_n_p,
  uart_cmd_initiator_if.master        bus
);

  localparam logic [23:0] C_TO_LAST = TIMEOUT_CYCLES - 24'd1;
  localparam logic [7:0]  C_START   = 8'h01;
  localparam logic [7:0]  C_CMD_RD  = 8'h02;
  localparam logic [7:0]  C_CMD_WR  = 8'h03;

  typedef enum logic [3:0] {
    IDLE           = 4'd0,
    SEND_START     = 4'd1,
    SEND_CMD       = 4'd2,
    SEND_ADRS_MSB  = 4'd3,
    SEND_ADRS_LSB  = 4'd4,
    SEND_WDATA_MSB = 4'd5,
    SEND_WDATA_LSB = 4'd6,
    WAIT_RSP_MSB   = 4'd7,
    WAIT_RSP_LSB   = 4'd8,
    DONE           = 4'd9
  } state_t;

  state_t      state_q,       state_d;
  logic        write_q,       write_d;
  logic [15:0] adrs_q,        adrs_d;
  logic [15:0] wdata_q,       wdata_d;
  logic [7:0]  tx_byte_q,     tx_byte_d;
  logic        tx_valid_q,    tx_valid_d;
  logic [7:0]  rsp_msb_q,     rsp_msb_d;
  logic [15:0] rsp_data_q,    rsp_data_d;
  logic        rsp_valid_q,   rsp_valid_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        req_ready_q,   req_ready_d;
  logic        busy_q,        busy_d;
  logic [23:0] cnt_q,         cnt_d;

  logic        w_tx_xfer;
  logic        w_expired;
  logic [23:0] w_cnt_inc;

  assign w_tx_xfer = tx_valid_q & bus.tx_byte_ready_p;
  // ">=" rather than "==": a byte that wins the race against expiry in
  // WAIT_RSP_MSB moves on with the counter already past the last cycle, and
  // the second byte must still be bounded by the same deadline.
  assign w_expired = (cnt_q >= C_TO_LAST);
  assign w_cnt_inc = (cnt_q == 24'hFF_FFFF) ? cnt_q : cnt_q + 24'd1;

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    adrs_d        = adrs_q;
    wdata_d       = wdata_q;
    tx_byte_d     = tx_byte_q;
    tx_valid_d    = tx_valid_q;
    rsp_msb_d     = rsp_msb_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        cnt_d = 24'd0;
        if (bus.req_valid_p && req_ready_q) begin
          write_d    = bus.req_write_p;
          adrs_d     = bus.req_adrs_p;
          wdata_d    = bus.req_wr_data_p;
          tx_byte_d  = C_START;
          tx_valid_d = 1'b1;
          state_d    = SEND_START;
        end
      end

      // Each send state holds its byte until the TX stage takes it, then
      // loads the next byte in the same edge so bytes can go back-to-back.
      SEND_START: begin
        if (w_tx_xfer) begin
          tx_byte_d = write_q ? C_CMD_WR : C_CMD_RD;
          state_d   = SEND_CMD;
        end
      end

      SEND_CMD: begin
        if (w_tx_xfer) begin
          tx_byte_d = adrs_q[15:8];
          state_d   = SEND_ADRS_MSB;
        end
      end

      SEND_ADRS_MSB: begin
        if (w_tx_xfer) begin
          tx_byte_d = adrs_q[7:0];
          state_d   = SEND_ADRS_LSB;
        end
      end

      SEND_ADRS_LSB: begin
        if (w_tx_xfer) begin
          if (write_q) begin
            tx_byte_d = wdata_q[15:8];
            state_d   = SEND_WDATA_MSB;
          end else begin
            tx_valid_d = 1'b0;
            cnt_d      = 24'd0;
            state_d    = WAIT_RSP_MSB;
          end
        end
      end

      SEND_WDATA_MSB: begin
        if (w_tx_xfer) begin
          tx_byte_d = wdata_q[7:0];
          state_d   = SEND_WDATA_LSB;
        end
      end

      // Writes are not acknowledged by the responder.
      SEND_WDATA_LSB: begin
        if (w_tx_xfer) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      // A strobe in the expiry cycle takes priority over the timeout.
      WAIT_RSP_MSB: begin
        if (bus.rx_byte_valid_p) begin
          rsp_msb_d = bus.rx_byte_p;
          cnt_d     = w_cnt_inc;
          state_d   = WAIT_RSP_LSB;
        end else if (w_expired) begin
          rsp_timeout_d = 1'b1;
          cnt_d         = 24'd0;
          state_d       = IDLE;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end

      WAIT_RSP_LSB: begin
        if (bus.rx_byte_valid_p) begin
          rsp_data_d  = {rsp_msb_q, bus.rx_byte_p};
          rsp_valid_d = 1'b1;
          cnt_d       = 24'd0;
          state_d     = DONE;
        end else if (w_expired) begin
          rsp_timeout_d = 1'b1;
          cnt_d         = 24'd0;
          state_d       = IDLE;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end

      // rsp_valid_p is high during this state; it was set on entry.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        tx_valid_d = 1'b0;
        cnt_d      = 24'd0;
        state_d    = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      adrs_q        <= 16'd0;
      wdata_q       <= 16'd0;
      tx_byte_q     <= 8'd0;
      tx_valid_q    <= 1'b0;
      rsp_msb_q     <= 8'd0;
      rsp_data_q    <= 16'd0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      cnt_q         <= 24'd0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      adrs_q        <= adrs_d;
      wdata_q       <= wdata_d;
      tx_byte_q     <= tx_byte_d;
      tx_valid_q    <= tx_valid_d;
      rsp_msb_q     <= rsp_msb_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.req_ready_p     = req_ready_q;
  assign bus.tx_byte_p       = tx_byte_q;
  assign bus.tx_byte_valid_p = tx_valid_q;
  assign bus.rsp_data_p      = rsp_data_q;
  assign bus.rsp_valid_p     = rsp_valid_q;
  assign bus.rsp_timeout_p   = rsp_timeout_q;
  assign bus.busy_p          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_initiator
// Description : Directed bench for uart_cmd_initiator with TIMEOUT_CYCLES=100.
//               Inputs are driven and outputs sampled 1 ns after the rising
//               clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_initiator;

  logic clk210_p  = 1'b0;
  logic reset_n_p = 1'b0;
  int   n_err     = 0;
  int   n_checks  = 0;
  int   rsp_pulses = 0;
  int   to_pulses  = 0;

  uart_cmd_initiator_if u_if ();

  uart_cmd_initiator #(.TIMEOUT_CYCLES(24'd100)) u_dut (
    .clk210_p  (clk210_p),
    .reset_n_p (reset_n_p),
    .bus       (u_if)
  );

  always #5 clk210_p = ~clk210_p;

  always @(negedge clk210_p) begin
    if (u_if.rsp_valid_p === 1'b1)   rsp_pulses++;
    if (u_if.rsp_timeout_p === 1'b1) to_pulses++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk210_p);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic wr, input logic [15:0] adrs, input logic [15:0] wd);
    u_if.req_valid_p   = 1'b1;
    u_if.req_write_p   = wr;
    u_if.req_adrs_p    = adrs;
    u_if.req_wr_data_p = wd;
    step();
    u_if.req_valid_p   = 1'b0;
  endtask

  // Waits (bounded) for a transfer cycle, checks the byte, crosses the edge.
  task automatic expect_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!(u_if.tx_byte_valid_p && u_if.tx_byte_ready_p) && n < 50) begin
      step();
      n++;
    end
    chk({tag, " xfer"}, 32'(u_if.tx_byte_valid_p & u_if.tx_byte_ready_p), 32'd1);
    chk(tag, 32'(u_if.tx_byte_p), 32'(exp));
    step();
  endtask

  task automatic rx_byte(input logic [7:0] b);
    u_if.rx_byte_p       = b;
    u_if.rx_byte_valid_p = 1'b1;
    step();
    u_if.rx_byte_valid_p = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " req_ready"},   32'(u_if.req_ready_p),     32'd1);
    chk({tag, " tx_valid"},    32'(u_if.tx_byte_valid_p), 32'd0);
    chk({tag, " tx_byte"},     32'(u_if.tx_byte_p),       32'd0);
    chk({tag, " rsp_data"},    32'(u_if.rsp_data_p),      32'd0);
    chk({tag, " rsp_valid"},   32'(u_if.rsp_valid_p),     32'd0);
    chk({tag, " rsp_timeout"}, 32'(u_if.rsp_timeout_p),   32'd0);
    chk({tag, " busy"},        32'(u_if.busy_p),          32'd0);
  endtask

  initial begin
    int k;
    int p0;
    u_if.req_valid_p     = 1'b0;
    u_if.req_write_p     = 1'b0;
    u_if.req_adrs_p      = 16'd0;
    u_if.req_wr_data_p   = 16'd0;
    u_if.tx_byte_ready_p = 1'b1;
    u_if.rx_byte_p       = 8'd0;
    u_if.rx_byte_valid_p = 1'b0;

    // ---------------- reset values
    repeat (3) step();
    chk_reset_vals("reset");
    reset_n_p = 1'b1;
    step();

    // ---------------- read 0x1234, ready tied high -> 0xBEEF
    request(1'b0, 16'h1234, 16'h0000);
    chk("rd busy",      32'(u_if.busy_p),          32'd1);
    chk("rd req_ready", 32'(u_if.req_ready_p),     32'd0);
    chk("rd b0",        32'(u_if.tx_byte_p),       32'h01);
    chk("rd v0",        32'(u_if.tx_byte_valid_p), 32'd1);
    step();
    chk("rd b1",        32'(u_if.tx_byte_p),       32'h02);
    step();
    chk("rd b2",        32'(u_if.tx_byte_p),       32'h12);
    step();
    chk("rd b3",        32'(u_if.tx_byte_p),       32'h34);
    chk("rd v3",        32'(u_if.tx_byte_valid_p), 32'd1);
    step();
    chk("rd tx idle",   32'(u_if.tx_byte_valid_p), 32'd0);
    rx_byte(8'hBE);
    step();
    rx_byte(8'hEF);
    chk("rd rsp_valid", 32'(u_if.rsp_valid_p),     32'd1);
    chk("rd rsp_data",  32'(u_if.rsp_data_p),      32'hBEEF);
    chk("rd ready in done", 32'(u_if.req_ready_p), 32'd0);
    step();
    chk("rd pulse end", 32'(u_if.rsp_valid_p),     32'd0);
    chk("rd ready next", 32'(u_if.req_ready_p),    32'd1);
    chk("rd pulses",    32'(rsp_pulses),           32'd1);

    // ---------------- write 0x00A5 <- 0xC3D2
    p0 = rsp_pulses;
    request(1'b1, 16'h00A5, 16'hC3D2);
    expect_byte("wr b0", 8'h01);
    expect_byte("wr b1", 8'h03);
    expect_byte("wr b2", 8'h00);
    expect_byte("wr b3", 8'hA5);
    expect_byte("wr b4", 8'hC3);
    expect_byte("wr b5", 8'hD2);
    chk("wr tx idle",   32'(u_if.tx_byte_valid_p), 32'd0);
    chk("wr req_ready", 32'(u_if.req_ready_p),     32'd1);
    chk("wr busy",      32'(u_if.busy_p),          32'd0);
    repeat (5) step();
    chk("wr no rsp",    32'(rsp_pulses - p0),      32'd0);

    // ---------------- backpressure during SEND_ADRS_MSB
    request(1'b0, 16'h1234, 16'h0000);
    expect_byte("bp b0", 8'h01);
    expect_byte("bp b1", 8'h02);
    u_if.tx_byte_ready_p = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp hold byte",  32'(u_if.tx_byte_p),       32'h12);
      chk("bp hold valid", 32'(u_if.tx_byte_valid_p), 32'd1);
    end
    u_if.tx_byte_ready_p = 1'b1;
    expect_byte("bp b2", 8'h12);
    expect_byte("bp b3", 8'h34);
    chk("bp tx idle",   32'(u_if.tx_byte_valid_p), 32'd0);
    rx_byte(8'hAA);
    rx_byte(8'h55);
    chk("bp rsp_valid", 32'(u_if.rsp_valid_p),     32'd1);
    chk("bp rsp_data",  32'(u_if.rsp_data_p),      32'hAA55);
    step();

    // ---------------- timeout: one byte after 20 cycles, none after
    p0 = rsp_pulses;
    request(1'b0, 16'h0200, 16'h0000);
    expect_byte("to b0", 8'h01);
    expect_byte("to b1", 8'h02);
    expect_byte("to b2", 8'h02);
    expect_byte("to b3", 8'h00);
    k = 0;
    repeat (19) begin step(); k++; end
    rx_byte(8'h77);
    k++;
    while (!u_if.rsp_timeout_p && k < 300) begin
      step();
      k++;
    end
    chk("to latency",   32'(k),                    32'd100);
    chk("to pulse",     32'(u_if.rsp_timeout_p),   32'd1);
    chk("to data kept", 32'(u_if.rsp_data_p),      32'hAA55);
    chk("to req_ready", 32'(u_if.req_ready_p),     32'd1);
    step();
    chk("to pulse end", 32'(u_if.rsp_timeout_p),   32'd0);
    rx_byte(8'h99);
    step();
    chk("to late busy", 32'(u_if.busy_p),          32'd0);
    chk("to no rsp",    32'(rsp_pulses - p0),      32'd0);
    chk("to count",     32'(to_pulses),            32'd1);
    request(1'b0, 16'h0300, 16'h0000);
    expect_byte("to2 b0", 8'h01);
    expect_byte("to2 b1", 8'h02);
    expect_byte("to2 b2", 8'h03);
    expect_byte("to2 b3", 8'h00);
    rx_byte(8'h13);
    rx_byte(8'h57);
    chk("to2 rsp_valid", 32'(u_if.rsp_valid_p),    32'd1);
    chk("to2 rsp_data",  32'(u_if.rsp_data_p),     32'h1357);
    step();

    // ---------------- stray rx byte in IDLE
    rx_byte(8'h55);
    step();
    chk("stray busy",   32'(u_if.busy_p),          32'd0);
    request(1'b0, 16'h0040, 16'h0000);
    expect_byte("st b0", 8'h01);
    expect_byte("st b1", 8'h02);
    expect_byte("st b2", 8'h00);
    expect_byte("st b3", 8'h40);
    rx_byte(8'h01);
    rx_byte(8'h02);
    chk("st rsp_valid", 32'(u_if.rsp_valid_p),     32'd1);
    chk("st rsp_data",  32'(u_if.rsp_data_p),      32'h0102);
    step();

    // ---------------- reset during SEND_CMD
    p0 = rsp_pulses;
    request(1'b0, 16'h0010, 16'h0000);
    step();
    chk("rst in cmd",   32'(u_if.tx_byte_p),       32'h02);
    reset_n_p = 1'b0;
    #1;
    chk_reset_vals("rst mid");
    step();
    step();
    reset_n_p = 1'b1;
    step();
    chk_reset_vals("rst after");
    chk("rst no rsp",   32'(rsp_pulses - p0),      32'd0);
    request(1'b0, 16'h0010, 16'h0000);
    expect_byte("rs b0", 8'h01);
    expect_byte("rs b1", 8'h02);
    expect_byte("rs b2", 8'h00);
    expect_byte("rs b3", 8'h10);
    rx_byte(8'hCA);
    rx_byte(8'hFE);
    chk("rs rsp_valid", 32'(u_if.rsp_valid_p),     32'd1);
    chk("rs rsp_data",  32'(u_if.rsp_data_p),      32'hCAFE);
    step();
    chk("rs idle",      32'(u_if.req_ready_p),     32'd1);
    chk("final to count", 32'(to_pulses),          32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
